// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one single-precision add/sub unit among N requesters.
// Operands are latched at grant; a watchdog returns a quiet NaN with err if the unit hangs.
module fpu_addsub_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      req_oper,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      done,
    output logic [31:0]       res,
    output logic              err,
    output logic              fpu_start,
    output logic              fpu_oper,
    output logic [31:0]       fpu_a,
    output logic [31:0]       fpu_b,
    input  logic              fpu_ready,
    input  logic [31:0]       fpu_r
);

    localparam int unsigned   PW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned   TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic [31:0]     res_q, res_d;
    logic            err_q, err_d;
    logic            start_q, start_d;
    logic            oper_q, oper_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;

    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   win_next;
    logic            tmo;

    // Rotating search starting at ptr; first set request wins.
    always_comb begin
        int unsigned pos;
        win_valid = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr_q) + k) % N;
            if (!win_valid && req[pos]) begin
                win_valid = 1'b1;
                win_idx   = PW'(pos);
            end
        end
        win_next = (32'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
    end

    assign tmo = (tcnt_q == TLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            tcnt_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            oper_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            tcnt_q  <= tcnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            start_q <= start_d;
            oper_q  <= oper_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (win_valid) state_d = ISSUE;
            ISSUE:     if (!fpu_ready) state_d = WAIT_DONE;
                       else if (tmo)   state_d = IDLE;
            WAIT_DONE: if (fpu_ready || tmo) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        tcnt_d  = tcnt_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        res_d   = res_q;
        start_d = start_q;
        oper_d  = oper_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    sel_d   = win_idx;
                    a_d     = req_a[32*int'(win_idx) +: 32];
                    b_d     = req_b[32*int'(win_idx) +: 32];
                    oper_d  = req_oper[win_idx];
                    gnt_d   = N'(1) << win_idx;
                    ptr_d   = win_next;
                    tcnt_d  = '0;
                    start_d = 1'b1;
                end
            end
            ISSUE: begin
                if (!fpu_ready) begin
                    start_d = 1'b0;
                    tcnt_d  = '0;
                end else if (tmo) begin
                    res_d   = QNAN;
                    err_d   = 1'b1;
                    done_d  = N'(1) << sel_q;
                    start_d = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (fpu_ready) begin
                    res_d  = fpu_r;
                    done_d = N'(1) << sel_q;
                end else if (tmo) begin
                    res_d   = QNAN;
                    err_d   = 1'b1;
                    done_d  = N'(1) << sel_q;
                    start_d = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign res       = res_q;
    assign err       = err_q;
    assign fpu_start = start_q;
    assign fpu_oper  = oper_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a behavioural add/sub unit model.
module tb_fpu_addsub_arbiter;

    localparam int unsigned N       = 4;
    localparam int unsigned TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_oper;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     res;
    logic            err;
    logic            fpu_start;
    logic            fpu_oper;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic            fpu_ready;
    logic [31:0]     fpu_r;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Unit model: 0 = normal, 1 = ready stuck high, 2 = ready stuck low after start
    int          mode = 0;
    int          lat  = 3;
    int          busy_cnt;
    logic [31:0] model_r = '0;

    fpu_addsub_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_oper  (req_oper),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .done      (done),
        .res       (res),
        .err       (err),
        .fpu_start (fpu_start),
        .fpu_oper  (fpu_oper),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_ready (fpu_ready),
        .fpu_r     (fpu_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpu_ready <= 1'b1;
            fpu_r     <= '0;
            busy_cnt  <= 0;
        end else begin
            case (mode)
                0: begin
                    if (fpu_ready && fpu_start) begin
                        fpu_ready <= 1'b0;
                        busy_cnt  <= lat;
                    end else if (!fpu_ready) begin
                        if (busy_cnt == 0) begin
                            fpu_ready <= 1'b1;
                            fpu_r     <= model_r;
                        end else begin
                            busy_cnt <= busy_cnt - 1;
                        end
                    end
                end
                1: fpu_ready <= 1'b1;
                default: if (fpu_start) fpu_ready <= 1'b0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(input logic [N-1:0] exp);
        int unsigned n = 0;
        @(negedge clk);
        while (gnt == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("gnt", 32'(gnt), 32'(exp));
    endtask

    task automatic wait_done(input logic [N-1:0] exp);
        int unsigned n = 0;
        @(negedge clk);
        while (done == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done", 32'(done), 32'(exp));
    endtask

    task automatic do_op(input int idx, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r);
        model_r              = r;
        req_oper[idx]        = op;
        req_a[idx*32 +: 32]  = a;
        req_b[idx*32 +: 32]  = b;
        req[idx]             = 1'b1;
        wait_gnt(N'(1) << idx);
        chk("start_at_gnt", 32'(fpu_start), 32'd1);
        chk("fpu_a", fpu_a, a);
        chk("fpu_b", fpu_b, b);
        chk("fpu_oper", 32'(fpu_oper), 32'(op));
        req[idx] = 1'b0;
        @(negedge clk);
        chk("gnt_pulse", 32'(gnt), 32'd0);
        chk("start_hold", 32'(fpu_start), 32'd1);
        @(negedge clk);
        chk("start_drop", 32'(fpu_start), 32'd0);
        wait_done(N'(1) << idx);
        chk("res", res, r);
        chk("err", 32'(err), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("res_held", res, r);
    endtask

    initial begin
        int          exp_order [5] = '{0, 1, 2, 3, 0};
        int unsigned ngnt, ndone, n, seen;
        logic        outstanding;
        logic [N-1:0] lastg;
        logic [31:0]  exp_g, exp_a;

        reset    = 1'b0;
        req      = '0;
        req_oper = '0;
        req_a    = '0;
        req_b    = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_start", 32'(fpu_start), 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 4.0 + 2.0, then 24.0 - 2.0
        do_op(0, 1'b0, 32'h4080_0000, 32'h4000_0000, 32'h40C0_0000);
        do_op(2, 1'b1, 32'h41C0_0000, 32'h4000_0000, 32'h41B0_0000);

        // ptr must now be 3
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = 32'h3F80_0000 + 32'(i);
            req_b[i*32 +: 32] = 32'h4040_0000 + 32'(i);
            req_oper[i]       = i[0];
        end
        model_r = 32'h1234_5678;
        req = 4'hF;
        wait_gnt(4'b1000);
        req = '0;
        wait_done(4'b1000);
        chk("ptr3_res", res, 32'h1234_5678);

        // Contention: all requesting, each re-raises after its done
        req         = 4'hF;
        ngnt        = 0;
        ndone       = 0;
        outstanding = 1'b0;
        lastg       = '0;
        for (int cyc = 0; cyc < 1000 && ndone < 5; cyc++) begin
            @(negedge clk);
            if (gnt != '0) begin
                exp_g = (ngnt < 5) ? 32'(1) << exp_order[ngnt] : 32'd0;
                exp_a = (ngnt < 5) ? 32'h3F80_0000 + 32'(exp_order[ngnt]) : 32'd0;
                chk("cont_gnt", 32'(gnt), exp_g);
                chk("cont_overlap", 32'(outstanding), 32'd0);
                chk("cont_a", fpu_a, exp_a);
                outstanding = 1'b1;
                lastg       = gnt;
                req         = req & ~gnt;
                ngnt++;
                model_r = 32'h4000_0000 | ngnt;
            end
            if (done != '0) begin
                chk("cont_done", 32'(done), 32'(lastg));
                chk("cont_res", res, model_r);
                outstanding = 1'b0;
                ndone++;
                if (ndone < 5) req = req | done;
                else           req = '0;
            end
        end
        chk("cont_count", ndone, 32'd5);

        // Wrap: serve 3 (ptr -> 0), then 1001 grants 0 then 3
        do_op(3, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        model_r = 32'hAAAA_0000;
        req = 4'b1001;
        wait_gnt(4'b0001);
        req[0] = 1'b0;
        wait_done(4'b0001);
        model_r = 32'hBBBB_0000;
        wait_gnt(4'b1000);
        req[3] = 1'b0;
        wait_done(4'b1000);
        chk("wrap_res", res, 32'hBBBB_0000);

        // Watchdog in ISSUE: unit never drops ready
        mode   = 1;
        req[1] = 1'b1;
        wait_gnt(4'b0010);
        req[1] = 1'b0;
        n = (fpu_start) ? 1 : 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (done != '0) break;
            if (fpu_start) n++;
        end
        chk("tmo1_start_cycles", n, TIMEOUT);
        chk("tmo1_done", 32'(done), 32'b0010);
        chk("tmo1_err", 32'(err), 32'd1);
        chk("tmo1_res", res, 32'h7FC0_0000);
        chk("tmo1_start", 32'(fpu_start), 32'd0);
        @(negedge clk);
        chk("tmo1_err_pulse", 32'(err), 32'd0);
        chk("tmo1_done_pulse", 32'(done), 32'd0);

        // Watchdog in WAIT_DONE: ready stuck low
        mode   = 2;
        req[2] = 1'b1;
        wait_gnt(4'b0100);
        req[2] = 1'b0;
        wait_done(4'b0100);
        chk("tmo2_err", 32'(err), 32'd1);
        chk("tmo2_res", res, 32'h7FC0_0000);
        chk("tmo2_start", 32'(fpu_start), 32'd0);
        mode = 0;
        repeat (5) @(negedge clk);

        // Reset while the unit is busy
        lat            = 10;
        req_a[3*32 +: 32] = 32'h4120_0000;
        req[3]         = 1'b1;
        wait_gnt(4'b1000);
        req[3] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_start", 32'(fpu_start), 32'd0);
        chk("mid_rst_oper", 32'(fpu_oper), 32'd0);
        chk("mid_rst_res", res, 32'd0);
        chk("mid_rst_a", fpu_a, 32'd0);
        chk("mid_rst_b", fpu_b, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        lat   = 3;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        chk("mid_rst_no_done", seen, 32'd0);
        model_r = 32'hCAFE_0001;
        req = 4'b1001;
        wait_gnt(4'b0001);
        req = '0;
        wait_done(4'b0001);
        chk("post_rst_res", res, 32'hCAFE_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
- Shares one IEEE-754 single-precision add/sub unit (start/oper/A/B/R/ready interface) among N requesters.
- Round-robin arbitration; latches the winner's operands and drives the unit's start until the unit acknowledges by dropping ready.
- Waits for ready to rise again, then returns R to the winner with a one-cycle done pulse.
- A watchdog aborts a hung operation with a quiet-NaN result and an error flag.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles allowed in ISSUE or in WAIT_DONE before abort (must be ≥ 8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  N  per-requester request level, sampled only in IDLE.
- req_oper  in  N  per-requester operation: 0 = add, 1 = subtract.
- req_a  in  32*N  operand A; requester i is at bits [32i+31:32i].
- req_b  in  32*N  operand B, same packing as req_a.
- gnt  out  N  one-hot, one-cycle pulse: request accepted and operands captured.
- done  out  N  one-hot, one-cycle pulse: res/err valid for that requester.
- res  out  32  result; held until the next done.
- err  out  1  high in the done cycle when the operation timed out.
- fpu_start  out  1  start to the add/sub unit.
- fpu_oper  out  1  latched oper.
- fpu_a  out  32  latched A.
- fpu_b  out  32  latched B.
- fpu_ready  in  1  unit ready; low = busy, high = idle/result valid.
- fpu_r  in  32  unit result.

Behaviour:
- All outputs are registered. On reset = 0 (asynchronous):
  - gnt, done, err, fpu_start, fpu_oper = 0.
  - res, fpu_a, fpu_b = 0.
  - state = IDLE, pointer ptr = 0, timeout counter tcnt = 0.
  - Reset mid-operation abandons the operation with no done pulse.
- States are IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - With req != 0, select the first set bit searching ptr, ptr+1, …, N-1, 0, … (wraps mod N).
  - On that edge: sel <= winner; fpu_a/fpu_b/fpu_oper <= winner's inputs; gnt[winner] <= 1; ptr <= (winner+1) mod N; tcnt <= 0; fpu_start <= 1; go to ISSUE.
  - With req == 0, stay in IDLE.
- ISSUE:
  - gnt returns to 0 after one cycle. fpu_start stays high until fpu_ready is sampled 0.
  - When fpu_ready = 0: fpu_start <= 0, tcnt <= 0, go to WAIT_DONE.
  - Otherwise tcnt increments; when tcnt = TIMEOUT-1, abort.
- WAIT_DONE:
  - When fpu_ready = 1: res <= fpu_r, done[sel] <= 1, err <= 0, go to IDLE.
  - Otherwise tcnt increments; when tcnt = TIMEOUT-1, abort.
- Abort:
  - res <= 32'h7FC00000, err <= 1, done[sel] <= 1, fpu_start <= 0, go to IDLE.
- done and err last exactly one cycle.
- fpu_a, fpu_b, fpu_oper remain stable from the grant edge until the next grant, independent of later changes on req_*.
- Minimum latency from request to done: 1 grant cycle + ISSUE + unit latency + 1 capture cycle. A new grant is possible on the cycle after done; there is no pipelining.
- Requesters deassert req on seeing gnt. A req still high when the arbiter returns to IDLE is treated as a new request.
- Simultaneous requests: only one grant per IDLE visit; the others wait.
- ptr advances past the winner, so a requester that keeps re-requesting cannot starve others.
- No operand checking: special values (zero/Inf/NaN) pass through unchanged and are handled by the unit.

Test Plan:
- Single request, add: N=4, req[0]=1, A=0x40800000 (4.0), B=0x40000000 (2.0), oper=0 → gnt[0] pulse; fpu_start high until ready falls; done[0] pulse; res=0x40C00000; err=0.
- Subtract: req[2], A=0x41C00000 (24.0), B=0x40000000, oper=1 → done[2]; res=0x41B00000 (22.0); ptr=3 afterwards.
- Contention: req=4'b1111 held, each requester dropping req on gnt and re-raising it after its done → grant order 0,1,2,3,0; each done follows its gnt; no two gnt pulses without a done in between.
- Wrap priority: after serving requester 3, request req=4'b1001 → requester 0 wins; then requester 3 wins on the next IDLE visit.
- Timeout: unit model holds ready=1 forever → fpu_start high for TIMEOUT cycles, then done[sel]=1, err=1, res=0x7FC00000, fpu_start=0. Repeat with ready stuck low after start → same abort from WAIT_DONE.
- Reset mid-operation: reset=0 while in WAIT_DONE → all outputs 0 immediately; after release, no done pulse; a new request is granted normally starting from ptr=0.
